// File: rtl/pipe_tx_width_adapter_if.sv
// Scrambler-side word handshake and PIPE TX beat bus of the TX width adapter.
interface pipe_tx_width_adapter_if;
    logic [31:0] in_data;
    logic [3:0]  in_datak;
    logic [1:0]  in_sync_header;
    logic        in_start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] TxData;
    logic [3:0]  TxDataK;
    logic        TxDataValid;
    logic [1:0]  TxSyncHeader;
    logic        TxStartBlock;
    logic        block_err;

    modport master (
        output in_data, in_datak, in_sync_header, in_start, in_valid,
        input  in_ready, TxData, TxDataK, TxDataValid, TxSyncHeader, TxStartBlock, block_err
    );

    modport slave (
        input  in_data, in_datak, in_sync_header, in_start, in_valid,
        output in_ready, TxData, TxDataK, TxDataValid, TxSyncHeader, TxStartBlock, block_err
    );
endinterface

// File: rtl/pipe_tx_width_adapter.sv
// Buffers 32-bit scrambler words and serialises them onto the per-generation
// PIPE TX width, with 128b/130b start-block framing and block-alignment checking.
module pipe_tx_width_adapter #(
    parameter int PIPE_W_GEN1 = 8,
    parameter int PIPE_W_GEN2 = 8,
    parameter int PIPE_W_GEN3 = 16,
    parameter int PIPE_W_GEN4 = 32,
    parameter int PIPE_W_GEN5 = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                    pclk,
    input  logic                    reset_n,
    input  logic [2:0]              generation,
    pipe_tx_width_adapter_if.slave  bus
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  datak;
        logic [1:0]  sync_header;
        logic        start;
    } word_t;

    function automatic logic [5:0] width_of(input logic [2:0] g);
        case (g)
            3'd1:    width_of = 6'(PIPE_W_GEN1);
            3'd2:    width_of = 6'(PIPE_W_GEN2);
            3'd3:    width_of = 6'(PIPE_W_GEN3);
            3'd4:    width_of = 6'(PIPE_W_GEN4);
            3'd5:    width_of = 6'(PIPE_W_GEN5);
            default: width_of = 6'd32;
        endcase
    endfunction

    word_t          mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [AW:0]    count_r;
    logic [1:0]     slice_r;
    logic [1:0]     blk_cnt_r, blk_cnt_s;
    logic [2:0]     gen_prev_r;
    logic           gen_init_r;

    word_t          head_s;
    logic [5:0]     w_s, shift_s;
    logic [31:0]    dmask_s;
    logic [3:0]     kmask_s;
    logic [1:0]     last_slice_s;
    logic           gen_ok_s, gen_chg_s, run_s, mode128_s;
    logic           ready_s, push_s, beat_s, pop_s;

    logic [31:0]    tx_data_s, tx_data_r;
    logic [3:0]     tx_k_s, tx_k_r;
    logic           tx_valid_s, tx_valid_r;
    logic [1:0]     tx_sh_s, tx_sh_r;
    logic           tx_start_s, tx_start_r;
    logic           blk_err_s, blk_err_r;

    // Mode decode, handshake and FIFO/slice control
    always_comb begin
        w_s       = width_of(generation);
        gen_ok_s  = (generation >= 3'd1) && (generation <= 3'd5);
        gen_chg_s = gen_init_r && (generation != gen_prev_r);
        run_s     = gen_ok_s && !gen_chg_s;
        mode128_s = (generation >= 3'd3);
        ready_s   = reset_n && run_s && (count_r < DEPTH_C);
        push_s    = bus.in_valid && ready_s;
        beat_s    = run_s && (count_r != {(AW + 1){1'b0}});
        head_s    = mem_r[rd_ptr_r];
        shift_s   = {4'd0, slice_r} * w_s;
        case (w_s)
            6'd8: begin
                last_slice_s = 2'd3;
                dmask_s      = 32'h0000_00FF;
                kmask_s      = 4'h1;
            end
            6'd16: begin
                last_slice_s = 2'd1;
                dmask_s      = 32'h0000_FFFF;
                kmask_s      = 4'h3;
            end
            default: begin
                last_slice_s = 2'd0;
                dmask_s      = 32'hFFFF_FFFF;
                kmask_s      = 4'hF;
            end
        endcase
        pop_s = beat_s && (slice_r == last_slice_s);
    end

    // Next beat on the PIPE side; the sync header only changes on a start beat
    always_comb begin
        tx_data_s  = 32'd0;
        tx_k_s     = 4'd0;
        tx_valid_s = 1'b0;
        tx_start_s = 1'b0;
        if (!run_s || !mode128_s) begin
            tx_sh_s = 2'b00;
        end else begin
            tx_sh_s = tx_sh_r;
        end
        if (beat_s) begin
            tx_data_s  = (head_s.data >> shift_s) & dmask_s;
            tx_valid_s = 1'b1;
            if (mode128_s) begin
                if ((slice_r == 2'd0) && head_s.start) begin
                    tx_start_s = 1'b1;
                    tx_sh_s    = head_s.sync_header;
                end else begin
                    tx_start_s = 1'b0;
                end
            end else begin
                tx_k_s = (head_s.datak >> shift_s[5:3]) & kmask_s;
            end
        end else begin
            tx_valid_s = 1'b0;
        end
    end

    // Block word counter: a start word always resynchronises the count to 1
    always_comb begin
        blk_err_s = 1'b0;
        blk_cnt_s = blk_cnt_r;
        if (!run_s) begin
            blk_cnt_s = 2'd0;
        end else if (push_s && mode128_s) begin
            blk_err_s = bus.in_start ? (blk_cnt_r != 2'd0) : (blk_cnt_r == 2'd0);
            blk_cnt_s = bus.in_start ? 2'd1 : (blk_cnt_r + 2'd1);
        end else begin
            blk_err_s = 1'b0;
        end
    end

    // FIFO pointers, occupancy, slice and block counters
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {(AW + 1){1'b0}};
            slice_r   <= 2'd0;
            blk_cnt_r <= 2'd0;
        end else if (!run_s) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {(AW + 1){1'b0}};
            slice_r   <= 2'd0;
            blk_cnt_r <= 2'd0;
        end else begin
            wr_ptr_r  <= push_s ? (wr_ptr_r + AW'(1'b1)) : wr_ptr_r;
            rd_ptr_r  <= pop_s  ? (rd_ptr_r + AW'(1'b1)) : rd_ptr_r;
            count_r   <= count_r + (AW + 1)'(push_s) - (AW + 1)'(pop_s);
            slice_r   <= pop_s ? 2'd0 : (beat_s ? (slice_r + 2'd1) : slice_r);
            blk_cnt_r <= blk_cnt_s;
        end
    end

    // Word storage
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {$bits(word_t){1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.in_data, bus.in_datak, bus.in_sync_header, bus.in_start};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Registered PIPE outputs and generation history
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            tx_data_r  <= 32'd0;
            tx_k_r     <= 4'd0;
            tx_valid_r <= 1'b0;
            tx_sh_r    <= 2'b00;
            tx_start_r <= 1'b0;
            blk_err_r  <= 1'b0;
            gen_prev_r <= 3'd0;
            gen_init_r <= 1'b0;
        end else begin
            tx_data_r  <= tx_data_s;
            tx_k_r     <= tx_k_s;
            tx_valid_r <= tx_valid_s;
            tx_sh_r    <= tx_sh_s;
            tx_start_r <= tx_start_s;
            blk_err_r  <= blk_err_s;
            gen_prev_r <= generation;
            gen_init_r <= 1'b1;
        end
    end

    assign bus.in_ready     = ready_s;
    assign bus.TxData       = tx_data_r;
    assign bus.TxDataK      = tx_k_r;
    assign bus.TxDataValid  = tx_valid_r;
    assign bus.TxSyncHeader = tx_sh_r;
    assign bus.TxStartBlock = tx_start_r;
    assign bus.block_err    = blk_err_r;
endmodule

// File: tb/tb_pipe_tx_width_adapter.sv
// Random and directed stimulus for pipe_tx_width_adapter, checked against a
// queue-based beat model of the serialisation and block-framing rules.
module tb_pipe_tx_width_adapter;
    logic       pclk;
    logic       reset_n;
    logic [2:0] generation;

    pipe_tx_width_adapter_if bus();

    pipe_tx_width_adapter dut (
        .pclk       (pclk),
        .reset_n    (reset_n),
        .generation (generation),
        .bus        (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  k;
        logic [1:0]  sh;
        bit          st;
    } mword_t;

    int     vec_cnt = 0;
    int     err_cnt = 0;

    mword_t m_q[$];
    int     m_beat, m_bcnt, m_prev;
    bit     m_init;
    logic [31:0] e_data;
    logic [3:0]  e_k;
    logic        e_val, e_st, e_err;
    logic [1:0]  e_sh;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pipe_w(input int g);
        if (g <= 2) return 8;
        else if (g == 3) return 16;
        else return 32;
    endfunction

    function automatic bit gen_ok(input int g);
        return (g >= 1) && (g <= 5);
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_beat = 0; m_bcnt = 0; m_prev = 0; m_init = 1'b0;
        e_data = 32'd0; e_k = 4'd0; e_val = 1'b0; e_sh = 2'b00; e_st = 1'b0; e_err = 1'b0;
    endfunction

    function automatic bit model_ready(input int g);
        return gen_ok(g) && !(m_init && (g != m_prev)) && (m_q.size() < 4);
    endfunction

    // One clock edge: emit the next beat of the head word, then take the accepted word
    function automatic void model_edge(input int g, input bit acc, input mword_t w);
        int wd;
        bit run;
        run   = gen_ok(g) && !(m_init && (g != m_prev));
        e_err = 1'b0;
        e_st  = 1'b0;
        if (!run) begin
            m_q.delete();
            m_beat = 0; m_bcnt = 0;
            e_data = 32'd0; e_k = 4'd0; e_val = 1'b0; e_sh = 2'b00;
        end else begin
            wd = pipe_w(g);
            if (m_q.size() > 0) begin
                e_data = 32'((64'(m_q[0].data) >> (m_beat * wd)) & ((64'd1 << wd) - 64'd1));
                e_k    = (g <= 2) ? 4'((32'(m_q[0].k) >> (m_beat * wd / 8)) & ((32'd1 << (wd / 8)) - 32'd1)) : 4'd0;
                e_val  = 1'b1;
                if (g >= 3 && m_beat == 0 && m_q[0].st) begin
                    e_st = 1'b1;
                    e_sh = m_q[0].sh;
                end
                m_beat++;
                if (m_beat == 32 / wd) begin
                    void'(m_q.pop_front());
                    m_beat = 0;
                end
            end else begin
                e_data = 32'd0; e_k = 4'd0; e_val = 1'b0;
            end
            if (g <= 2) e_sh = 2'b00;
            if (acc) begin
                m_q.push_back(w);
                if (g >= 3) begin
                    e_err  = w.st ? (m_bcnt != 0) : (m_bcnt == 0);
                    m_bcnt = w.st ? 1 : (m_bcnt + 1) % 4;
                end
            end
        end
        m_prev = g;
        m_init = 1'b1;
    endfunction

    task automatic step(input bit v, input logic [31:0] d, input logic [3:0] k,
                        input logic [1:0] sh, input bit st, output bit acc);
        bit     exp_rdy;
        mword_t w;
        bus.in_valid       = v;
        bus.in_data        = d;
        bus.in_datak       = k;
        bus.in_sync_header = sh;
        bus.in_start       = st;
        #1;
        exp_rdy = model_ready(int'(generation));
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        w   = '{data: d, k: k, sh: sh, st: st};
        @(posedge pclk);
        model_edge(int'(generation), acc, w);
        #1;
        check("TxData", bus.TxData, e_data);
        check("TxDataK", 32'(bus.TxDataK), 32'(e_k));
        check("TxDataValid", 32'(bus.TxDataValid), 32'(e_val));
        check("TxSyncHeader", 32'(bus.TxSyncHeader), 32'(e_sh));
        check("TxStartBlock", 32'(bus.TxStartBlock), 32'(e_st));
        check("block_err", 32'(bus.block_err), 32'(e_err));
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        #2;
        model_reset();
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_data", bus.TxData, 32'd0);
        check("rst_valid", 32'(bus.TxDataValid), 32'd0);
        check("rst_sh_start_err", {29'd0, bus.TxSyncHeader, bus.TxStartBlock | bus.block_err}, 32'd0);
        @(negedge pclk);
        reset_n = 1'b1;
    endtask

    initial begin
        bit          acc;
        bit          v, st, burst;
        int          pos, n, gsel;
        logic [31:0] tp1_data [5];
        logic [3:0]  tp1_k [5];
        bit          tp5_st [7];
        bit          tp5_err [7];

        tp1_data = '{32'hDD, 32'hCC, 32'hBB, 32'hAA, 32'h00};
        tp1_k    = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        tp5_st   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tp5_err  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        generation         = 3'd1;
        bus.in_data        = 32'd0;
        bus.in_datak       = 4'd0;
        bus.in_sync_header = 2'b00;
        bus.in_start       = 1'b0;
        bus.in_valid       = 1'b0;
        do_reset();

        // Gen1 byte serialisation of a single word
        step(1'b1, 32'hAABBCCDD, 4'b0001, 2'b00, 1'b0, acc);
        check("tp1_accept", 32'(acc), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'd0, 4'd0, 2'b00, 1'b0, acc);
            check("tp1_beat", bus.TxData, tp1_data[i]);
            check("tp1_k", 32'(bus.TxDataK), 32'(tp1_k[i]));
        end

        // Gen4 misplaced start word flags one error and resynchronises
        do_reset();
        generation = 3'd4;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, $urandom, 4'd0, 2'b10, tp5_st[i], acc);
            check("tp5_err", 32'(bus.block_err), 32'(tp5_err[i]));
        end

        // Random phases across all generations, with changes, bursts and resets
        for (int ph = 0; ph < 30; ph++) begin
            gsel = $urandom_range(0, 11);
            if (gsel < 10) generation = 3'((gsel % 5) + 1);
            else if (gsel == 10) generation = 3'd0;
            else generation = 3'(6 + $urandom_range(0, 1));
            burst = (ph % 3 == 0);
            n     = $urandom_range(20, 60);
            pos   = 0;
            for (int i = 0; i < n; i++) begin
                if (ph % 5 == 4 && i == n / 2) begin
                    do_reset();
                    pos = 0;
                end
                v  = burst || ($urandom_range(0, 3) != 0);
                st = (pos == 0);
                if ($urandom_range(0, 15) == 0) st = !st;
                step(v, $urandom, 4'($urandom), 2'($urandom), st, acc);
                if (acc) pos = st ? 1 : (pos + 1) % 4;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
